// File: rtl/io_port_bank_pkg.sv
// ----------------------------------------------------------------------------
// io_port_bank_pkg
// Shared defaults and helpers for the I/O port bank.
//   DEF_W           default data width of every port
//   DEF_NPORTS      default number of input and output ports
//   DEF_SYNC_STAGES default depth of each strobe synchronizer
//   sel_in_range()  true when a port select addresses an existing port
// ----------------------------------------------------------------------------
package io_port_bank_pkg;

    localparam int DEF_W           = 8;
    localparam int DEF_NPORTS      = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // Every port-indexed access goes through this check so that a select
    // value beyond NPORTS (possible when NPORTS is not a power of two)
    // never touches state.
    function automatic logic sel_in_range(input logic [31:0] sel,
                                          input logic [31:0] nports);
        return sel < nports;
    endfunction

endpackage

// File: rtl/io_port_bank_sync_edge.sv
// ----------------------------------------------------------------------------
// io_port_bank_sync_edge
// Brings one asynchronous strobe into the clk domain and produces a
// one-cycle pulse on each rising edge of the synchronized value.
//   clk        system clock
//   reset      asynchronous, active-high
//   async_in   asynchronous strobe from the pin
//   edge_pulse high for one cycle after the synchronized strobe rises
// ----------------------------------------------------------------------------
module io_port_bank_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift chain plus one delayed copy of its last stage. Both reset to 0,
    // so a strobe held high through reset release still yields exactly one
    // edge once it has walked through the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/io_port_bank.sv
// ----------------------------------------------------------------------------
// io_port_bank
// Parametrised input/output port bank for the single-cycle microcontroller.
// Input side: per-port strobed capture into a hold register with full and
// sticky overrun flags, read by the core through a combinational mux.
// Output side: per-port output registers with a one-cycle write strobe.
// A maskable, registered interrupt flags ports holding unread data.
//   clk       system clock
//   reset     asynchronous, active-high, clears all state
//   port_sel  port addressed by rd_en / wr_en
//   rd_en     core reads input port port_sel (clears its flags)
//   rd_data   hold register of port_sel, 0 for a nonexistent port
//   wr_en     core writes output port port_sel
//   wr_data   data for output write and interrupt-mask load
//   mask_we   load irq_mask from the low NPORTS bits of wr_data
//   in_data   packed input data, port p at [p*W +: W]
//   in_stb    asynchronous data-ready strobe per port
//   in_full   hold register p holds unread data
//   overrun   sticky: strobe arrived while port was full
//   irq       registered OR of (in_full & irq_mask)
//   out_data  packed output registers, port p at [p*W +: W]
//   out_stb   one-cycle pulse per port, aligned with out_data update
// ----------------------------------------------------------------------------
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter  int W           = DEF_W,
    parameter  int NPORTS      = DEF_NPORTS,
    parameter  int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int SELW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SELW-1:0]      port_sel,
    input  logic                 rd_en,
    output logic [W-1:0]         rd_data,
    input  logic                 wr_en,
    input  logic [W-1:0]         wr_data,
    input  logic                 mask_we,
    input  logic [NPORTS*W-1:0]  in_data,
    input  logic [NPORTS-1:0]    in_stb,
    output logic [NPORTS-1:0]    in_full,
    output logic [NPORTS-1:0]    overrun,
    output logic                 irq,
    output logic [NPORTS*W-1:0]  out_data,
    output logic [NPORTS-1:0]    out_stb
);

    logic              sel_valid;
    logic [NPORTS-1:0] cap;
    logic [NPORTS-1:0] rd_hit;
    logic [NPORTS-1:0] wr_hit;
    logic [NPORTS-1:0] irq_mask;
    logic [NPORTS-1:0] mask_next;
    logic [W-1:0]      hold [NPORTS];

    assign sel_valid = sel_in_range(32'(port_sel), 32'(NPORTS));

    // Mask bits beyond the data width have no source and load as 0.
    for (genvar i = 0; i < NPORTS; i++) begin : g_mask_src
        if (i < W) begin : g_bit
            assign mask_next[i] = wr_data[i];
        end else begin : g_zero
            assign mask_next[i] = 1'b0;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic [W-1:0] hold_q;
        logic [W-1:0] out_q;
        logic         full_q;
        logic         ovr_q;
        logic         stb_q;

        io_port_bank_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk        (clk),
            .reset      (reset),
            .async_in   (in_stb[p]),
            .edge_pulse (cap[p])
        );

        assign rd_hit[p] = rd_en & sel_valid & (port_sel == SELW'(p));
        assign wr_hit[p] = wr_en & sel_valid & (port_sel == SELW'(p));

        // Input capture. A capture on the same edge as a core read wins:
        // the read consumed the old data, so the new data is loaded, the
        // port stays full and any overrun is cleared. A capture into a full,
        // unread port keeps the oldest data and flags the loss instead.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hold_q <= '0;
                full_q <= 1'b0;
                ovr_q  <= 1'b0;
            end else if (cap[p] && (!full_q || rd_hit[p])) begin
                hold_q <= in_data[p*W +: W];
                full_q <= 1'b1;
                if (rd_hit[p]) begin
                    ovr_q <= 1'b0;
                end
            end else if (cap[p]) begin
                ovr_q <= 1'b1;
            end else if (rd_hit[p]) begin
                full_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
        end

        // Output register with a strobe that is high exactly in the cycle
        // after each write, so consecutive writes give consecutive pulses.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_q <= '0;
                stb_q <= 1'b0;
            end else begin
                stb_q <= wr_hit[p];
                if (wr_hit[p]) begin
                    out_q <= wr_data;
                end
            end
        end

        assign hold[p]             = hold_q;
        assign in_full[p]          = full_q;
        assign overrun[p]          = ovr_q;
        assign out_data[p*W +: W]  = out_q;
        assign out_stb[p]          = stb_q;
    end

    // Read mux; a select with no matching port leaves the default of 0.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (sel_valid && (port_sel == SELW'(p))) begin
                rd_data = hold[p];
            end
        end
    end

    // Interrupt mask may be loaded in the same cycle as an output write;
    // both use the same wr_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (mask_we) begin
            irq_mask <= mask_next;
        end
    end

    // Registered interrupt, so it trails in_full / irq_mask by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(in_full & irq_mask);
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// ----------------------------------------------------------------------------
// tb_io_port_bank
// Directed test of io_port_bank (W=8, NPORTS=4, SYNC_STAGES=2). Stimulus
// pushes expected values, stamped with the cycle they must appear in, into
// a scoreboard queue; a monitor on the falling edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_io_port_bank;

    localparam int SIG_RD   = 0;
    localparam int SIG_FULL = 1;
    localparam int SIG_OVR  = 2;
    localparam int SIG_IRQ  = 3;
    localparam int SIG_OUT  = 4;
    localparam int SIG_STB  = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  port_sel;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        mask_we;
    logic [31:0] in_data;
    logic [3:0]  in_stb;
    logic [3:0]  in_full;
    logic [3:0]  overrun;
    logic        irq;
    logic [31:0] out_data;
    logic [3:0]  out_stb;

    exp_t sb[$];
    int   cyc          = 0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    io_port_bank #(
        .W           (8),
        .NPORTS      (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .port_sel (port_sel),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .mask_we  (mask_we),
        .in_data  (in_data),
        .in_stb   (in_stb),
        .in_full  (in_full),
        .overrun  (overrun),
        .irq      (irq),
        .out_data (out_data),
        .out_stb  (out_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: value k means "just after rising edge k".
    always @(posedge clk) cyc++;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            SIG_RD:   return {24'h0, rd_data};
            SIG_FULL: return {28'h0, in_full};
            SIG_OVR:  return {28'h0, overrun};
            SIG_IRQ:  return {31'h0, irq};
            SIG_OUT:  return out_data;
            default:  return {28'h0, out_stb};
        endcase
    endfunction

    // Monitor: compares every expectation due this cycle, away from the
    // active edge. Anything overdue counts as a failure.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                logic [31:0] act;
                act = actual(sb[i].sig);
                tests_run++;
                if (sb[i].cyc < cyc || act !== sb[i].exp) begin
                    tests_failed++;
                    $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic checkOutput(input string name, input int sig,
                               input logic [31:0] exp, input int delay);
        exp_t e;
        e.cyc  = cyc + delay;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic mw,
                                 input int sel, input logic [7:0] data);
        rd_en    = rd;
        wr_en    = wr;
        mask_we  = mw;
        port_sel = 2'(sel);
        wr_data  = data;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setPort(input int p, input logic [7:0] data, input logic stb);
        in_data[p*8 +: 8] = data;
        in_stb[p]         = stb;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        in_stb  = 4'hF;
        in_data = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        step(3);

        // 1: reset release with all strobes already high
        reset = 1'b0;
        checkOutput("reset_rd_data",  SIG_RD,   32'h0, 0);
        checkOutput("reset_in_full",  SIG_FULL, 32'h0, 0);
        checkOutput("reset_overrun",  SIG_OVR,  32'h0, 0);
        checkOutput("reset_irq",      SIG_IRQ,  32'h0, 0);
        checkOutput("reset_out_data", SIG_OUT,  32'h0, 0);
        checkOutput("reset_out_stb",  SIG_STB,  32'h0, 0);
        checkOutput("release_full_early", SIG_FULL, 32'h0, 2);
        checkOutput("release_full",       SIG_FULL, 32'hF, 3);
        step(3);
        in_stb = 4'h0;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, p, 8'h00);
            step(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        checkOutput("drain_full", SIG_FULL, 32'h0, 0);
        checkOutput("drain_irq",  SIG_IRQ,  32'h0, 0);
        step(3);

        // 2: single capture on port 1, then read
        setPort(1, 8'hA5, 1'b1);
        checkOutput("p1_full_early", SIG_FULL, 32'h0, 2);
        checkOutput("p1_full",       SIG_FULL, 32'h2, 3);
        step(3);
        in_stb[1] = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1, 8'h00);
        checkOutput("p1_rd_data",    SIG_RD,   32'hA5, 0);
        checkOutput("p1_read_clear", SIG_FULL, 32'h0,  1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        step(3);

        // 3: overrun on port 2, oldest data kept, read clears both flags
        setPort(2, 8'h11, 1'b1);
        checkOutput("p2_first_full", SIG_FULL, 32'h4, 3);
        checkOutput("p2_first_ovr",  SIG_OVR,  32'h0, 3);
        step(3);
        in_stb[2] = 1'b0;
        step(3);
        setPort(2, 8'h22, 1'b1);
        checkOutput("p2_overrun",  SIG_OVR,  32'h4, 3);
        checkOutput("p2_full_ovr", SIG_FULL, 32'h4, 3);
        step(3);
        in_stb[2] = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 2, 8'h00);
        checkOutput("p2_oldest_kept", SIG_RD,   32'h11, 0);
        checkOutput("p2_full_clear",  SIG_FULL, 32'h0,  1);
        checkOutput("p2_ovr_clear",   SIG_OVR,  32'h0,  1);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        step(3);

        // 4: capture on port 0 in the same edge as its read
        setPort(0, 8'h33, 1'b1);
        step(3);
        in_stb[0] = 1'b0;
        step(3);
        setPort(0, 8'h44, 1'b1);
        step(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        checkOutput("p0_before_race", SIG_RD,   32'h33, 0);
        checkOutput("p0_full_before", SIG_FULL, 32'h1,  0);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        in_stb[0] = 1'b0;
        checkOutput("race_full_kept", SIG_FULL, 32'h1,  0);
        checkOutput("race_no_ovr",    SIG_OVR,  32'h0,  0);
        checkOutput("race_new_data",  SIG_RD,   32'h44, 0);
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 8'h00);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        checkOutput("p0_drained", SIG_FULL, 32'h0, 0);
        step(2);

        // 5: back-to-back output writes
        applyStimulus(1'b0, 1'b1, 1'b0, 3, 8'h5A);
        checkOutput("wr3_stb",  SIG_STB, 32'h8,        1);
        checkOutput("wr3_data", SIG_OUT, 32'h5A000000, 1);
        checkOutput("wr0_stb",  SIG_STB, 32'h1,        2);
        checkOutput("wr0_data", SIG_OUT, 32'h5A0000C3, 2);
        checkOutput("wr_stb_end", SIG_STB, 32'h0,      3);
        step(1);
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 8'hC3);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        step(2);

        // 6: mask load together with an output write, then irq behaviour
        applyStimulus(1'b0, 1'b1, 1'b1, 1, 8'h04);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        checkOutput("mask_wr_stb",  SIG_STB, 32'h2,        0);
        checkOutput("mask_wr_data", SIG_OUT, 32'h5A0004C3, 0);
        setPort(2, 8'h77, 1'b1);
        checkOutput("irq_p2_full",  SIG_FULL, 32'h4, 3);
        checkOutput("irq_lag",      SIG_IRQ,  32'h0, 3);
        checkOutput("irq_set",      SIG_IRQ,  32'h1, 4);
        step(3);
        in_stb[2] = 1'b0;
        step(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 2, 8'h00);
        checkOutput("irq_read_rd",  SIG_RD,  32'h77, 0);
        checkOutput("irq_held",     SIG_IRQ, 32'h1,  1);
        checkOutput("irq_cleared",  SIG_IRQ, 32'h0,  2);
        step(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 8'h00);
        step(1);
        setPort(0, 8'h99, 1'b1);
        checkOutput("masked_p0_full", SIG_FULL, 32'h1, 3);
        checkOutput("masked_p0_irq",  SIG_IRQ,  32'h0, 4);
        step(3);
        in_stb[0] = 1'b0;
        step(4);

        if (sb.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            tests_run    += sb.size();
            tests_failed += sb.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
